// File: rtl/seven_seg_capture.sv
`timescale 1ns/1ps
// seven_seg_capture
//   Watches a multiplexed, active-low seven-segment display bus and recovers
//   the decimal values shown on digit0 and digit1. A digit is accepted only
//   after its select/segment pattern has been stable for STABLE_CYCLES
//   synchronized cycles.
//
//   Optional feature macro: SEVEN_SEG_CAPTURE_DP_CHECK_EN
//     defined   : an accepted pattern with the decimal point lit sets err and
//                 stores nothing
//     undefined : the decimal point is ignored entirely
//
// Ports
//   clk25        in   1  sole clock, rising edge
//   reset        in   1  asynchronous active-low reset
//   segments     in   8  active-low segments, bit7=a .. bit1=g, bit0=dp
//   digitselect  in   4  active-low digit enables (1110 d0, 1101 d1, 0111 d3)
//   first        out  4  last accepted digit0 value
//   second       out  4  last accepted digit1 value
//   valid        out  1  both digit0 and digit1 accepted since reset
//   update       out  1  one-cycle pulse when first or second changes value
//   err          out  1  sticky: an illegal pattern was accepted
//
// FSM
//   state | meaning
//   IDLE  | no legal digit selected
//   TRACK | legal select, counting stable cycles
//   HOLD  | pattern accepted, waiting for the bus to change
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic [7:0] segments,
  input  logic [3:0] digitselect,
  output logic [3:0] first,
  output logic [3:0] second,
  output logic       valid,
  output logic       update,
  output logic       err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D3 = 4'b0111;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t      state, state_n;
  logic [11:0] sync1, sync2, prev;
  logic [7:0]  cnt;
  logic        changed, legal_sel, accept;

  logic        acc_q;
  logic [3:0]  cap_sel;
  logic [6:0]  cap_seg;
  logic        dp_bad;

  logic        have0, have1, have0_n, have1_n;
  logic [3:0]  first_n, second_n, dec_val;
  logic        err_n, upd_n, dec_ok, blank;

  // Synchronizer plus a third stage holding the previous synchronized value
  // for change detection. All-ones is the idle bus (nothing lit, no digit).
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {digitselect, segments};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign changed   = (sync2 != prev);
  assign legal_sel = (sync2[11:8] == SEL_D0) || (sync2[11:8] == SEL_D1) ||
                     (sync2[11:8] == SEL_D3);

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (changed)        cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (legal_sel) state_n = TRACK;
      TRACK: begin
        if (!legal_sel)                          state_n = IDLE;
        else if (!changed && (cnt == CNT_MAX))   state_n = HOLD;
      end
      HOLD: begin
        if (!legal_sel)   state_n = IDLE;
        else if (changed) state_n = TRACK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == TRACK) && (state_n == HOLD);
  end

  // Capture the accepted pattern on the transition edge; the result
  // registers act on it one cycle later.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      acc_q   <= 1'b0;
      cap_sel <= '1;
      cap_seg <= '1;
    end else begin
      acc_q <= accept;
      if (accept) begin
        cap_sel <= sync2[11:8];
        cap_seg <= sync2[7:1];
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_DP_CHECK_EN
  logic cap_dp_lit;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset)      cap_dp_lit <= 1'b0;
    else if (accept) cap_dp_lit <= ~sync2[0];
  end

  assign dp_bad = cap_dp_lit;
`else
  assign dp_bad = 1'b0;
`endif

  // Decode with dp forced off so the table reads in the usual 8-bit form.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    blank   = ({cap_seg, 1'b1} == 8'hFF);
    case ({cap_seg, 1'b1})
      8'h03:   dec_val = 4'h0;
      8'h9F:   dec_val = 4'h1;
      8'h25:   dec_val = 4'h2;
      8'h0D:   dec_val = 4'h3;
      8'h99:   dec_val = 4'h4;
      8'h49:   dec_val = 4'h5;
      8'h41:   dec_val = 4'h6;
      8'h1F:   dec_val = 4'h7;
      8'h01:   dec_val = 4'h8;
      8'h09:   dec_val = 4'h9;
      8'h71:   dec_val = 4'hF;
      default: dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    first_n  = first;
    second_n = second;
    have0_n  = have0;
    have1_n  = have1;
    err_n    = err;
    upd_n    = 1'b0;
    if (acc_q) begin
      if (dp_bad) begin
        err_n = 1'b1;
      end else if (blank) begin
        err_n = err;
      end else if (!dec_ok) begin
        err_n = 1'b1;
      end else begin
        case (cap_sel)
          SEL_D0: begin
            have0_n = 1'b1;
            first_n = dec_val;
            upd_n   = (dec_val != first);
          end
          SEL_D1: begin
            have1_n  = 1'b1;
            second_n = dec_val;
            upd_n    = (dec_val != second);
          end
          // digit3 is only expected to show 0; anything else is a fault
          SEL_D3:  if (dec_val != 4'h0) err_n = 1'b1;
          default: err_n = err;
        endcase
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      first  <= '0;
      second <= '0;
      have0  <= 1'b0;
      have1  <= 1'b0;
      valid  <= 1'b0;
      update <= 1'b0;
      err    <= 1'b0;
    end else begin
      first  <= first_n;
      second <= second_n;
      have0  <= have0_n;
      have1  <= have1_n;
      valid  <= have0_n & have1_n;
      update <= upd_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
`timescale 1ns/1ps
module tb_seven_seg_capture;

  localparam int STABLE = 16;

  logic       clk25 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] segments = 8'hFF;
  logic [3:0] digitselect = 4'b1111;
  logic [3:0] first, second;
  logic       valid, update, err;

  seven_seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk25       (clk25),
    .reset       (reset),
    .segments    (segments),
    .digitselect (digitselect),
    .first       (first),
    .second      (second),
    .valid       (valid),
    .update      (update),
    .err         (err)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    logic [3:0] first;
    logic [3:0] second;
    logic       valid;
    logic       err;
    int         pulses;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;
  int lat        = 0;
  int edge_n     = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input logic [3:0] f, input logic [3:0] s,
                            input logic v, input logic e, input int p);
    exp_t x;
    x.first = f; x.second = s; x.valid = v; x.err = e; x.pulses = p;
    sb.push_back(x);
  endtask

  task automatic check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      cmp({tag, "_first"},  32'(first),  32'(x.first));
      cmp({tag, "_second"}, 32'(second), 32'(x.second));
      cmp({tag, "_valid"},  32'(valid),  32'(x.valid));
      cmp({tag, "_err"},    32'(err),    32'(x.err));
      cmp({tag, "_pulses"}, 32'(pulses), 32'(x.pulses));
    end
  endtask

  task automatic clear_obs();
    pulses = 0;
    lat    = 0;
    edge_n = 0;
  endtask

  // Called #1 after a rising edge; drives the bus and watches `cycles` edges.
  task automatic step(input logic [3:0] sel, input logic [7:0] seg, input int cycles);
    digitselect = sel;
    segments    = seg;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk25);
      #1;
      edge_n++;
      if (update) begin
        pulses++;
        if (lat == 0) lat = edge_n;
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    clear_obs();
    reset = 1'b0;
    #1;
    check(tag);
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // reset held from time 0
    clear_obs();
    expect_out(4'h0, 4'h0, 1'b0, 1'b0, 0);
    #5;
    check("reset_state");
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b1;

    // digit0 shows 1. The first edge that samples the input is cycle N;
    // the output changes at edge N+STABLE+3, i.e. STABLE+4 edges after the drive.
    clear_obs();
    expect_out(4'h1, 4'h0, 1'b0, 1'b0, 1);
    step(4'b1110, 8'h9F, 30);
    check("d0_one");
    cmp("d0_one_latency", 32'(lat), 32'(STABLE + 4));

    clear_obs();
    expect_out(4'h1, 4'h2, 1'b1, 1'b0, 1);
    step(4'b1101, 8'h25, 30);
    check("d1_two");

    // deselect, then re-apply the same value: accepted again, no pulse
    clear_obs();
    expect_out(4'h1, 4'h2, 1'b1, 1'b0, 0);
    step(4'b1111, 8'h25, 4);
    step(4'b1101, 8'h25, 30);
    check("d1_reapply");

    clear_obs();
    expect_out(4'hF, 4'h2, 1'b1, 1'b0, 1);
    step(4'b1110, 8'h71, 30);
    check("d0_F");

    clear_obs();
    expect_out(4'hF, 4'h3, 1'b1, 1'b0, 1);
    step(4'b1101, 8'h0D, 30);
    check("d1_three");

    clear_obs();
    expect_out(4'h6, 4'h3, 1'b1, 1'b0, 1);
    step(4'b1110, 8'h41, 30);
    check("d0_six");

    clear_obs();
    expect_out(4'h6, 4'h3, 1'b1, 1'b0, 0);
    step(4'b1110, 8'hFF, 30);
    check("d0_blank");

    // never stable long enough to accept
    clear_obs();
    expect_out(4'h6, 4'h3, 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++) step(4'b1110, (k % 2 == 0) ? 8'h9F : 8'h25, 10);
    check("d0_toggle");

    // all segments lit including dp
    clear_obs();
`ifdef SEVEN_SEG_CAPTURE_DP_CHECK_EN
    expect_out(4'h6, 4'h3, 1'b1, 1'b1, 0);
`else
    expect_out(4'h8, 4'h3, 1'b1, 1'b0, 1);
`endif
    step(4'b1110, 8'h00, 30);
    check("d0_all_lit");

    clear_obs();
`ifdef SEVEN_SEG_CAPTURE_DP_CHECK_EN
    expect_out(4'h6, 4'h3, 1'b1, 1'b1, 0);
`else
    expect_out(4'h8, 4'h3, 1'b1, 1'b0, 0);
`endif
    step(4'b0111, 8'h03, 30);
    check("d3_zero");

    clear_obs();
`ifdef SEVEN_SEG_CAPTURE_DP_CHECK_EN
    expect_out(4'h6, 4'h3, 1'b1, 1'b1, 0);
`else
    expect_out(4'h8, 4'h3, 1'b1, 1'b1, 0);
`endif
    step(4'b1101, 8'h55, 30);
    check("d1_illegal");

    expect_out(4'h0, 4'h0, 1'b0, 1'b0, 0);
    reset_pulse("reset_after_illegal");

    clear_obs();
    expect_out(4'h0, 4'h0, 1'b0, 1'b1, 0);
    step(4'b0111, 8'h9F, 30);
    check("d3_one");

    expect_out(4'h0, 4'h0, 1'b0, 1'b0, 0);
    reset_pulse("reset_after_d3");

    // reset 10 cycles into a window; 15 cycles afterwards are not enough
    clear_obs();
    expect_out(4'h0, 4'h0, 1'b0, 1'b0, 0);
    step(4'b1110, 8'h9F, 10);
    reset = 1'b0;
    repeat (2) @(posedge clk25);
    #1;
    reset = 1'b1;
    step(4'b1110, 8'h9F, 15);
    check("midreset_abandon");

    // holding on completes a fresh full window
    expect_out(4'h1, 4'h0, 1'b0, 1'b0, 1);
    step(4'b1110, 8'h9F, 10);
    check("midreset_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive synchronized cycles a select/segment pattern must hold before acceptance; legal range 2..255.
REQ-002 clk25  input  1  sole clock, all flops rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 segments  input  8  active-low segment lines; bit7=a … bit1=g, bit0=dp.
REQ-005 digitselect  input  4  active-low digit enables; 4'b1110=digit0, 4'b1101=digit1, 4'b0111=digit3.
REQ-006 first  output  4  last accepted value of digit0.
REQ-007 second  output  4  last accepted value of digit1.
REQ-008 valid  output  1  high once both digit0 and digit1 have been accepted since reset.
REQ-009 update  output  1  one-cycle pulse when first or second changes value.
REQ-010 err  output  1  sticky flag; illegal pattern accepted; cleared only by reset.

Function
REQ-011 segments and digitselect SHALL pass through a 2-flop synchronizer; all later logic uses the stage-2 values only.
REQ-012 Stability counter SHALL clear to 0 whenever the synchronized 12-bit {digitselect,segments} differs from the previous cycle, else increment, saturating at STABLE_CYCLES-1.
REQ-013 FSM states: IDLE (no selected digit), TRACK (counting), HOLD (pattern accepted, waiting for change).
REQ-014 IDLE->TRACK when digitselect is one of the three legal codes; TRACK->HOLD when counter reaches STABLE_CYCLES-1 with input unchanged; HOLD->TRACK on any input change to a legal select code; any state->IDLE on illegal/none select code (e.g. 4'b1111, 4'b1100).
REQ-015 Acceptance SHALL occur exactly once per TRACK->HOLD transition; outputs registered the cycle after the transition.
REQ-016 Decode (segments with dp masked): 8'h03->0, 8'h9F->1, 8'h25->2, 8'h0D->3, 8'h99->4, 8'h49->5, 8'h41->6, 8'h1F->7, 8'h01->8, 8'h09->9, 8'h71->4'hF.
REQ-017 Blank pattern 8'hFF (dp masked) SHALL be accepted without storing, err or update.
REQ-018 Any other pattern accepted on digit0/digit1 SHALL set err and leave first/second unchanged.
REQ-019 Digit3 accepted pattern other than value 0 SHALL set err; digit3 never stored.
REQ-020 update SHALL pulse only if the newly stored value differs from the held value; same-value re-acceptance produces no pulse.
REQ-021 Latency: stable input applied at cycle N yields output change at cycle N+STABLE_CYCLES+2 (+1 register): N+STABLE_CYCLES+3.

Reset
REQ-022 On reset low, asynchronously: first=0, second=0, valid=0, update=0, err=0, counter=0, synchronizers=all-ones, FSM=IDLE.
REQ-023 Reset assertion mid-TRACK SHALL abandon the pending pattern; after release, a full STABLE_CYCLES window is required again.

Configuration
REQ-024 Macro SEVEN_SEG_CAPTURE_DP_CHECK_EN: when defined, an accepted pattern with dp lit (bit0=0) SHALL set err and store nothing; when undefined, dp is ignored entirely.

Verification
REQ-025 digitselect=4'b1110, segments=8'h9F held 30 cycles -> first=4'h1 at cycle N+19, update one pulse, valid=0.
REQ-026 then digitselect=4'b1101, segments=8'h25 held 30 cycles -> second=4'h2, valid=1, update one pulse; re-apply same -> no pulse.
REQ-027 digitselect=4'b1110, segments=8'h00 held 30 cycles -> macro undefined: first=4'h8, err=0; macro defined: first unchanged, err=1.
REQ-028 segments toggled between 8'h9F and 8'h25 every 10 cycles on digit0 -> no acceptance, first/update unchanged.
REQ-029 digitselect=4'b0111, segments=8'h9F held 30 cycles -> err=1, first/second unchanged; reset pulse -> all outputs 0.
REQ-030 reset asserted at cycle 10 of a 16-cycle stable window, released, pattern held 15 more cycles -> no acceptance.
